// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin front end for one shared combinational barrel
// shifter. It grants one requester, issues its operands to the shifter from
// registers, captures the result, and returns it tagged with the requester id.
module shifter_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int REQS  = 4,
  localparam int SW    = $clog2(WIDTH),
  localparam int IW    = $clog2(REQS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQS-1:0]      req_valid,
  output logic [REQS-1:0]      req_ready,
  input  logic [REQS*WIDTH-1:0] req_a,
  input  logic [REQS*SW-1:0]   req_shamt,
  input  logic [REQS*2-1:0]    req_op,
  output logic [WIDTH-1:0]     sh_a,
  output logic [SW-1:0]        sh_shamt,
  output logic [1:0]           sh_op,
  input  logic [WIDTH-1:0]     sh_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic [IW-1:0]        resp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} st_t;

  // Operands captured at grant; the shifter is fed only from here.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    shamt;
    logic [1:0]       op;
    logic [IW-1:0]    id;
  } iss_t;

  st_t  state, state_nx;
  iss_t iss;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          gnt_hit;
  logic          accept;

  logic [REQS-1:0][WIDTH-1:0] a_l;
  logic [REQS-1:0][SW-1:0]    shamt_l;
  logic [REQS-1:0][1:0]       op_l;

  // Unpack the flat per-requester buses into indexable lanes.
  for (genvar i = 0; i < REQS; i++) begin : g_lane
    assign a_l[i]     = req_a[i*WIDTH +: WIDTH];
    assign shamt_l[i] = req_shamt[i*SW +: SW];
    assign op_l[i]    = req_op[i*2 +: 2];
  end

  // First valid requester at or above rr_ptr, wrapping; the IW-bit sum wraps
  // naturally because REQS is a power of two.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < REQS; k++) begin
      cand = rr_ptr + IW'(k);
      if (!gnt_hit && req_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept = (state == IDLE) && gnt_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: grant, one execute cycle, then hold until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_hit)    state_nx = EXEC;
      EXEC:                    state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Output decode: ready only toward the granted, currently valid requester.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
    busy = (state != IDLE);
  end

  // Issue registers and round-robin pointer advance on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss    <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      iss.a     <= a_l[gnt_idx];
      iss.shamt <= shamt_l[gnt_idx];
      iss.op    <= op_l[gnt_idx];
      iss.id    <= gnt_idx;
      rr_ptr    <= gnt_idx + 1'b1;
    end
  end

  assign sh_a     = iss.a;
  assign sh_shamt = iss.shamt;
  assign sh_op    = iss.op;

  // Response capture in EXEC; valid drops on the consuming edge, data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else if (state == EXEC) begin
      resp_valid <= 1'b1;
      resp_data  <= sh_result;
      resp_id    <= iss.id;
    end else if (state == RESP && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter with a behavioural shared shifter.
module tb_shifter_arbiter;
  localparam int WIDTH = 32;
  localparam int REQS  = 4;
  localparam int SW    = 5;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REQS-1:0]       req_valid;
  logic [REQS-1:0]       req_ready;
  logic [REQS*WIDTH-1:0] req_a;
  logic [REQS*SW-1:0]    req_shamt;
  logic [REQS*2-1:0]     req_op;
  logic [WIDTH-1:0]      sh_a;
  logic [SW-1:0]         sh_shamt;
  logic [1:0]            sh_op;
  logic [WIDTH-1:0]      sh_result;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IW-1:0]         resp_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  shifter_arbiter #(.WIDTH(WIDTH), .REQS(REQS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_shamt(req_shamt), .req_op(req_op),
    .sh_a(sh_a), .sh_shamt(sh_shamt), .sh_op(sh_op), .sh_result(sh_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared combinational shifter standing in for the real Mux-based one.
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_a << sh_shamt;
      2'b01:   sh_result = sh_a >> sh_shamt;
      2'b10:   sh_result = WIDTH'($signed(sh_a) >>> sh_shamt);
      default: sh_result = sh_a;
    endcase
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a,
                         input logic [SW-1:0] s, input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_shamt[i*SW +: SW]   = s;
    req_op[i*2 +: 2]        = op;
  endtask

  // One clock, leaving the bench at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1;
    req_a = '0; req_shamt = '0; req_op = '0;
    @(negedge clk); @(negedge clk);
    checks++; if ({resp_valid, resp_data, resp_id} !== '0) begin errors++;
      $display("FAIL reset_resp: got v=%b d=%h id=%0d want 0", resp_valid, resp_data, resp_id); end
    checks++; if ({sh_a, sh_shamt, sh_op} !== '0) begin errors++;
      $display("FAIL reset_sh: got a=%h s=%0d op=%0d want 0", sh_a, sh_shamt, sh_op); end
    checks++; if ({busy, req_ready} !== 5'b0) begin errors++;
      $display("FAIL reset_busy_ready: got busy=%b rdy=%b want 0", busy, req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL reset_first_grant: got %b want 0010", req_ready); end
    req_valid = '0;   // withdraw before any edge; pointer stays at 0
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d [5];
    int exp_id [5];
    set_req(0, 32'h0000_0001, 5'd1, 2'b00);
    set_req(1, 32'h0000_0010, 5'd2, 2'b00);
    set_req(2, 32'h0000_0100, 5'd3, 2'b00);
    set_req(3, 32'h1000_0000, 5'd4, 2'b01);
    exp_d  = '{32'h0000_0002, 32'h0000_0040, 32'h0000_0800, 32'h0100_0000, 32'h0000_0002};
    exp_id = '{0, 1, 2, 3, 0};
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++; if (req_ready !== (4'b0001 << exp_id[n])) begin errors++;
        $display("FAIL rr_grant%0d: got %b want id %0d", n, req_ready, exp_id[n]); end
      cyc();
      checks++; if (busy !== 1'b1 || req_ready !== 4'b0 || resp_valid !== 1'b0) begin errors++;
        $display("FAIL rr_exec%0d: got busy=%b rdy=%b v=%b want 1/0000/0", n, busy, req_ready, resp_valid); end
      cyc();
      checks++; if (resp_valid !== 1'b1 || resp_id !== IW'(exp_id[n]) || resp_data !== exp_d[n]) begin errors++;
        $display("FAIL rr_resp%0d: got v=%b id=%0d d=%h want 1 %0d %h", n, resp_valid, resp_id, resp_data, exp_id[n], exp_d[n]); end
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_single_sra();
    set_req(2, 32'h8000_00F0, 5'd4, 2'b10);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100 || busy !== 1'b0) begin errors++;
      $display("FAIL sra_ready: got rdy=%b busy=%b want 0100 0", req_ready, busy); end
    cyc();
    req_valid = '0;
    checks++; if (sh_a !== 32'h8000_00F0 || sh_shamt !== 5'd4 || sh_op !== 2'b10 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL sra_issue: got a=%h s=%0d op=%0d v=%b want 800000f0 4 2 0", sh_a, sh_shamt, sh_op, resp_valid); end
    cyc();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hF800_000F || resp_id !== 2'd2) begin errors++;
      $display("FAIL sra_resp: got v=%b d=%h id=%0d want 1 f800000f 2", resp_valid, resp_data, resp_id); end
    cyc();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL sra_done: got v=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_stall();
    set_req(1, 32'h0000_0001, 5'd31, 2'b00);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL stall_grant: got %b want 0010", req_ready); end
    cyc();
    req_valid = 4'b1000;   // another requester waits; must not be granted while stalled
    cyc();
    for (int n = 0; n < 5; n++) begin
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h8000_0000 || resp_id !== 2'd1 || req_ready !== 4'b0) begin errors++;
        $display("FAIL stall_hold%0d: got v=%b d=%h id=%0d rdy=%b want 1 80000000 1 0000", n, resp_valid, resp_data, resp_id, req_ready); end
      cyc();
    end
    resp_ready = 1'b1;
    req_valid = '0;
    cyc();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL stall_release: got v=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h0000_00FF, 5'd4, 2'b00);
    set_req(1, 32'h0000_F000, 5'd8, 2'b01);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL mid_in_exec: got busy=%b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || sh_a !== '0) begin errors++;
      $display("FAIL mid_reset_state: got busy=%b v=%b sh_a=%h want 0 0 0", busy, resp_valid, sh_a); end
    cyc();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++; if (resp_valid !== 1'b0) begin errors++;
        $display("FAIL mid_no_resp%0d: got v=%b want 0", n, resp_valid); end
    end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL mid_next_grant: got %b want 0010", req_ready); end
    cyc();
    req_valid = 4'b1000;
    cyc();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'h0000_00F0) begin errors++;
      $display("FAIL mid_resp: got v=%b id=%0d d=%h want 1 1 000000f0", resp_valid, resp_id, resp_data); end
    cyc();
  endtask

  task automatic test_wrap_withdraw();
    set_req(3, 32'h0000_0F00, 5'd8, 2'b01);
    set_req(0, 32'h0000_0003, 5'd2, 2'b00);
    // requester 3 still valid from the previous task; pointer is 2 -> grant 3
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++;
      $display("FAIL wrap_grant3: got %b want 1000", req_ready); end
    cyc(); req_valid = '0; cyc(); cyc();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL wrap_grant0: got %b want 0001", req_ready); end
    cyc();
    req_valid = 4'b1010;   // 0 done, 1 raises while busy
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++;
      $display("FAIL wrap_busy_ready: got %b want 0000", req_ready); end
    cyc();
    req_valid = 4'b1000;   // 1 withdraws before ever being granted
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'h0000_000C) begin errors++;
      $display("FAIL wrap_resp0: got v=%b id=%0d d=%h want 1 0 0000000c", resp_valid, resp_id, resp_data); end
    cyc();
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++;
      $display("FAIL wrap_after_withdraw: got %b want 1000", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 32'h0000_000F) begin errors++;
      $display("FAIL wrap_resp3: got v=%b id=%0d d=%h want 1 3 0000000f", resp_valid, resp_id, resp_data); end
    cyc();
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL wrap_idle: got busy=%b v=%b want 0 0", busy, resp_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_sra();
    test_stall();
    test_reset_mid();
    test_wrap_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
